// File: rtl/fifo_address_gen.sv
//------------------------------------------------------------------------------
// fifo_address_gen: circular address/pointer generator with lap bit for a
// power-of-two-deep FIFO. Optional Gray pointer when FIFO_ADDR_GEN_GRAY_EN.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module fifo_address_gen #(
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  inc,
  input  logic                  clr,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [ADDR_WIDTH-1:0] addr_next,
  output logic [ADDR_WIDTH:0]   ptr,
`ifdef FIFO_ADDR_GEN_GRAY_EN
  output logic [ADDR_WIDTH:0]   ptr_gray,
`endif
  output logic                  wrapped
);

  localparam logic [ADDR_WIDTH:0]   c_PTR_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] c_ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  logic [ADDR_WIDTH:0] r_ptr;
  logic                r_wrapped;
  logic [ADDR_WIDTH:0] w_ptr_next;
  logic                w_wrapped_next;

  // Lap bit is simply the carry out of the address field, so one adder covers both.
  always_comb begin
    w_ptr_next     = r_ptr;
    w_wrapped_next = 1'b0;
    if (rst || clr) begin
      w_ptr_next = '0;
    end else if (inc) begin
      w_ptr_next     = r_ptr + c_PTR_ONE;
      w_wrapped_next = &r_ptr[ADDR_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    r_ptr     <= w_ptr_next;
    r_wrapped <= w_wrapped_next;
  end

`ifdef FIFO_ADDR_GEN_GRAY_EN
  logic [ADDR_WIDTH:0] r_ptr_gray;

  always_ff @(posedge clk) begin
    r_ptr_gray <= w_ptr_next ^ (w_ptr_next >> 1);
  end

  assign ptr_gray = r_ptr_gray;
`endif

  assign ptr       = r_ptr;
  assign addr      = r_ptr[ADDR_WIDTH-1:0];
  assign addr_next = r_ptr[ADDR_WIDTH-1:0] + c_ADDR_ONE;
  assign wrapped   = r_wrapped;

endmodule

`default_nettype wire

// File: tb/tb_fifo_address_gen.sv
//------------------------------------------------------------------------------
// tb_fifo_address_gen: scoreboard bench with write and read pointer instances.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_fifo_address_gen;

  localparam int AW    = 4;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_inc = 1'b0, wr_clr = 1'b0;
  logic          rd_inc = 1'b0, rd_clr = 1'b0;
  logic [AW-1:0] wr_addr, wr_addr_next, rd_addr, rd_addr_next;
  logic [AW:0]   wr_ptr, rd_ptr;
  logic          wr_wrapped, rd_wrapped;
`ifdef FIFO_ADDR_GEN_GRAY_EN
  logic [AW:0]   wr_gray, rd_gray;
`endif

  fifo_address_gen #(.ADDR_WIDTH(AW)) u_wr (
    .clk(clk), .rst(rst), .inc(wr_inc), .clr(wr_clr),
    .addr(wr_addr), .addr_next(wr_addr_next), .ptr(wr_ptr),
`ifdef FIFO_ADDR_GEN_GRAY_EN
    .ptr_gray(wr_gray),
`endif
    .wrapped(wr_wrapped)
  );

  fifo_address_gen #(.ADDR_WIDTH(AW)) u_rd (
    .clk(clk), .rst(rst), .inc(rd_inc), .clr(rd_clr),
    .addr(rd_addr), .addr_next(rd_addr_next), .ptr(rd_ptr),
`ifdef FIFO_ADDR_GEN_GRAY_EN
    .ptr_gray(rd_gray),
`endif
    .wrapped(rd_wrapped)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] waddr;
    logic [AW-1:0] waddr_next;
    logic [AW:0]   wptr;
    logic          wwrap;
    logic [AW:0]   wgray;
    logic [AW:0]   rptr;
    logic [AW-1:0] raddr_next;
    logic          rwrap;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   wcnt  = 0;
  int   rcnt  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Model counts locations modulo 2*DEPTH; address is count mod DEPTH, lap is count/DEPTH.
  task automatic step(input logic r, input logic c, input logic wi, input logic ri);
    exp_t        e;
    logic        ww, rw;
    logic [AW:0] gray_before;
    int          g;
    ww = 1'b0;
    rw = 1'b0;
    rst = r; wr_clr = c; rd_clr = c; wr_inc = wi; rd_inc = ri;
`ifdef FIFO_ADDR_GEN_GRAY_EN
    gray_before = wr_gray;
`else
    gray_before = '0;
`endif
    if (r || c) begin
      wcnt = 0;
      rcnt = 0;
    end else begin
      if (wi) begin
        ww   = ((wcnt % DEPTH) == DEPTH - 1);
        wcnt = (wcnt + 1) % (2 * DEPTH);
      end
      if (ri) begin
        rw   = ((rcnt % DEPTH) == DEPTH - 1);
        rcnt = (rcnt + 1) % (2 * DEPTH);
      end
    end
    e.waddr      = AW'(wcnt % DEPTH);
    e.waddr_next = AW'((wcnt + 1) % DEPTH);
    e.wptr       = (AW + 1)'(wcnt);
    e.wwrap      = ww;
    g = wcnt ^ (wcnt >> 1);
    e.wgray      = (AW + 1)'(g);
    e.rptr       = (AW + 1)'(rcnt);
    e.raddr_next = AW'((rcnt + 1) % DEPTH);
    e.rwrap      = rw;
    q.push_back(e);

    @(posedge clk);
    #1;
    e = q.pop_front();
    check("wr_addr", 32'(wr_addr), 32'(e.waddr));
    check("wr_addr_next", 32'(wr_addr_next), 32'(e.waddr_next));
    check("wr_ptr", 32'(wr_ptr), 32'(e.wptr));
    check("wr_wrapped", 32'(wr_wrapped), 32'(e.wwrap));
    check("rd_ptr", 32'(rd_ptr), 32'(e.rptr));
    check("rd_addr_next", 32'(rd_addr_next), 32'(e.raddr_next));
    check("rd_wrapped", 32'(rd_wrapped), 32'(e.rwrap));
`ifdef FIFO_ADDR_GEN_GRAY_EN
    check("wr_gray", 32'(wr_gray), 32'(e.wgray));
    if (wi && !r && !c)
      check("gray_one_bit", 32'($countones(wr_gray ^ gray_before)), 32'd1);
`else
    if (gray_before != '0) check("gray_absent", 32'(gray_before), 32'd0);
`endif
  endtask

  initial begin
    // Reset for two cycles, then idle.
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);

    // 16 consecutive increments wrap the address and set the lap bit.
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b0, 1'b1, 1'b0);
    check("ptr_after_16", 32'(wr_ptr), 32'h10);
    check("wrap_after_16", 32'(wr_wrapped), 32'd1);
`ifdef FIFO_ADDR_GEN_GRAY_EN
    check("gray_at_10", 32'(wr_gray), 32'h18);
`endif
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("wrap_cleared", 32'(wr_wrapped), 32'd0);

    // Another 16 returns the full pointer to zero.
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b0, 1'b1, 1'b0);
    check("ptr_after_32", 32'(wr_ptr), 32'h00);

    // Write/read pair: 16 pushes -> full, 16 pops -> empty.
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b0, 1'b1, 1'b0);
    check("full", 32'(wr_addr == rd_addr && wr_ptr[AW] != rd_ptr[AW]), 32'd1);
    check("not_empty", 32'(wr_ptr == rd_ptr), 32'd0);
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
    check("empty", 32'(wr_ptr == rd_ptr), 32'd1);

    // Sparse increments to address 7, then clr with inc discards the inc.
    step(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) begin
      step(1'b0, 1'b0, 1'b1, 1'b1);
      step(1'b0, 1'b0, 1'b0, 1'b0);
    end
    check("sparse_addr7", 32'(wr_addr), 32'd7);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    check("clr_addr", 32'(wr_ptr), 32'd0);

    // Run to address 15, then reset with inc: no wrap pulse.
    for (int i = 0; i < DEPTH - 1; i++) step(1'b0, 1'b0, 1'b1, 1'b0);
    check("addr15", 32'(wr_addr), 32'd15);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    check("rst_no_wrap", 32'(wr_wrapped), 32'd0);

    // First inc after reset release lands on address 1.
    step(1'b0, 1'b0, 1'b1, 1'b0);
    check("post_rst_addr1", 32'(wr_addr), 32'd1);

    if (q.size() != 0) check("queue_drained", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
